aer_receiver: RTL and testbench
===============================

AER_RECEIVER -- requirements
Module: aer_receiver

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: event FIFO depth in entries, power of two.
REQ-002 Parameter FIFO_AW, default 4: FIFO address width, log2(FIFO_DEPTH).
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 AER_nreq  input  1  sender request, active-low, asynchronous to clk.
REQ-006 AER_data  input  10  sender word: bit9=0 row word (bits7:0 row, bit8 ignored); bit9=1 column word (bits8:1 x, bit0 polarity).
REQ-007 AER_nack  output  1  acknowledge to sender, active-low, registered.
REQ-008 ev_valid  output  1  FIFO head holds an event; equals FIFO not empty.
REQ-009 ev_ready  input  1  consumer accepts the head event when ev_valid=1.
REQ-010 ev_x  output  8  head event column.
REQ-011 ev_y  output  8  head event row, passed through exactly as received.
REQ-012 ev_pol  output  1  head event polarity.
REQ-013 fifo_count  output  FIFO_AW+1  current FIFO occupancy.
REQ-014 drop_cnt  output  16  count of column words dropped for lack of a row, saturating at 65535.
REQ-015 ev_cnt  output  16  count of events pushed into the FIFO, wrapping modulo 2^16.

Function
REQ-016 AER_nreq passes through a 2-flop synchronizer whose flops reset to 1; nreq_s is the second flop output; no other logic samples AER_nreq.
REQ-017 FSM states: IDLE, CHECK, ACK.
REQ-018 IDLE: when nreq_s=0, register AER_data into data_q and go to CHECK; otherwise stay; AER_nack=1.
REQ-019 CHECK, row word (data_q[9]=0): row_q<=data_q[7:0], row_valid<=1, AER_nack<=0, go to ACK.
REQ-020 CHECK, column word with row_valid=0: no push, drop_cnt increments (saturating), AER_nack<=0, go to ACK.
REQ-021 CHECK, column word with row_valid=1 and fifo_count<FIFO_DEPTH: push {row_q, data_q[8:1], data_q[0]}, ev_cnt increments, AER_nack<=0, go to ACK.
REQ-022 CHECK, column word with row_valid=1 and fifo_count=FIFO_DEPTH: stay in CHECK with AER_nack=1 (backpressure) until a pop frees space, then push in that cycle's CHECK evaluation.
REQ-023 ACK: hold AER_nack=0 until nreq_s=1, then AER_nack<=1 and go to IDLE.
REQ-024 Latency: AER_nack falls 4 clk edges after AER_nreq falls (2 sync, 1 latch, 1 CHECK) when no backpressure; push is visible on ev_valid on the same edge that AER_nack falls.
REQ-025 AER_data is sampled only once per handshake, in IDLE; changes during CHECK/ACK are ignored.
REQ-026 row_q persists across column words; every new row word overwrites it; row_valid stays 1 until reset.
REQ-027 FIFO is first-word-fall-through; pop occurs when ev_valid=1 and ev_ready=1; ev_x/ev_y/ev_pol are undefined but stable while ev_valid=0.
REQ-028 Simultaneous push and pop: both occur and fifo_count is unchanged; pop with ev_valid=0 is ignored; pointers wrap modulo FIFO_DEPTH.
REQ-029 In REQ-022, the full check uses the registered fifo_count, so a same-cycle pop does not enable the push; the push occurs one cycle later.
REQ-030 An undefined FSM state returns to IDLE with AER_nack=1.

Reset
REQ-031 On rst: state=IDLE, AER_nack=1, sync flops=1, data_q=0, row_q=0, row_valid=0, FIFO empty (ev_valid=0, fifo_count=0), drop_cnt=0, ev_cnt=0.
REQ-032 rst asserted mid-handshake forces AER_nack=1 immediately; any word in CHECK is discarded; after release, the block waits for nreq_s=0 in IDLE.

Verification
REQ-033 Row 0x0A4 (y=164), then column 0x3A5 (x=0xD2, pol=1), ev_ready=1 -> one event x=210, y=164, pol=1; ev_cnt=1; AER_nack low exactly 4 edges after each nreq fall.
REQ-034 Column 0x203 sent after reset with no row -> no event, drop_cnt=1, handshake completes normally (nack low then high).
REQ-035 ev_ready=0, one row then 17 columns x=0..16 -> 16 accepted; 17th handshake stalls with AER_nack=1; raise ev_ready for one cycle -> x=0 pops, x=16 is pushed one cycle later, and nack falls.
REQ-036 Sender holds AER_nreq low for 50 cycles -> AER_nack stays low throughout and rises 3 edges after AER_nreq rises; one event only.
REQ-037 Assert rst while in ACK -> AER_nack=1 and all counters=0 in the same cycle; subsequent row/column handshake produces a correct event.
REQ-038 Row y=5 with x=0..3, row y=6 with x=0..1, popped continuously -> six events in order, y=5,5,5,5,6,6; fifo_count returns to 0.

Source files
------------

// File: rtl/aer_receiver_if.sv
// AER receiver bus: asynchronous sender handshake plus the
// first-word-fall-through event stream presented to the consumer.
interface aer_receiver_if;
    logic       AER_nreq;
    logic [9:0] AER_data;
    logic       AER_nack;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_x;
    logic [7:0] ev_y;
    logic       ev_pol;

    modport master (
        output AER_nreq, AER_data, ev_ready,
        input  AER_nack, ev_valid, ev_x, ev_y, ev_pol
    );

    modport slave (
        input  AER_nreq, AER_data, ev_ready,
        output AER_nack, ev_valid, ev_x, ev_y, ev_pol
    );
endinterface

// File: rtl/aer_receiver.sv
// AER receiver: synchronizes the sender request, pairs column words with the
// latest row word and queues the resulting events in a FWFT FIFO.
module aer_receiver #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic               clk,
    input  logic               rst,
    aer_receiver_if.slave      bus,
    output logic [FIFO_AW:0]   fifo_count,
    output logic [15:0]        drop_cnt,
    output logic [15:0]        ev_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;

    localparam logic [FIFO_AW:0] FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

    logic [1:0]         state;
    logic               sync1;
    logic               nreq_s;
    logic [9:0]         data_q;
    logic [7:0]         row_q;
    logic               row_valid;
    logic               nack_q;
    logic [16:0]        mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               push;
    logic               pop;
    logic               has_room;

    // Full check uses the registered count, so a same-cycle pop
    // only unblocks the pending column on the following edge.
    assign has_room = fifo_count < FULL;
    assign push     = (state == CHECK) && data_q[9] && row_valid && has_room;
    assign pop      = bus.ev_valid && bus.ev_ready;

    assign bus.ev_valid = fifo_count != '0;
    assign bus.AER_nack = nack_q;
    assign {bus.ev_y, bus.ev_x, bus.ev_pol} = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b1;
            nreq_s <= 1'b1;
        end else begin
            sync1  <= bus.AER_nreq;
            nreq_s <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            nack_q    <= 1'b1;
            data_q    <= '0;
            row_q     <= '0;
            row_valid <= 1'b0;
            drop_cnt  <= '0;
            ev_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    nack_q <= 1'b1;
                    if (!nreq_s) begin
                        data_q <= bus.AER_data;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (!data_q[9]) begin
                        row_q     <= data_q[7:0];
                        row_valid <= 1'b1;
                        nack_q    <= 1'b0;
                        state     <= ACK;
                    end else if (!row_valid) begin
                        if (drop_cnt != 16'hFFFF)
                            drop_cnt <= drop_cnt + 16'd1;
                        nack_q <= 1'b0;
                        state  <= ACK;
                    end else if (has_room) begin
                        ev_cnt <= ev_cnt + 16'd1;
                        nack_q <= 1'b0;
                        state  <= ACK;
                    end else begin
                        nack_q <= 1'b1;
                    end
                end
                ACK: begin
                    if (nreq_s) begin
                        nack_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    nack_q <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {row_q, data_q[8:1], data_q[0]};
    end

endmodule

// File: tb/tb_aer_receiver.sv
// Randomized scoreboard bench for aer_receiver: a sender/model process queues
// expected events, a negedge monitor pops and compares every accepted event.
module tb_aer_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  fifo_count;
    logic [15:0] drop_cnt;
    logic [15:0] ev_cnt;

    int checks = 0;
    int errors = 0;

    logic        rdy_val  = 1'b0;
    logic        rdy_rand = 1'b0;

    logic [7:0]  m_row;
    bit          m_rv;
    int          m_ev;
    int          m_drop;
    logic [16:0] exp_q [$];

    aer_receiver_if bus ();

    aer_receiver #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fifo_count (fifo_count),
        .drop_cnt   (drop_cnt),
        .ev_cnt     (ev_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_row  = '0;
        m_rv   = 0;
        m_ev   = 0;
        m_drop = 0;
        exp_q.delete();
    endtask

    // Reference behaviour: rows set the current row, columns either make
    // an event from the current row or are dropped when none exists yet.
    task automatic model(input logic [9:0] w);
        if (!w[9]) begin
            m_row = w[7:0];
            m_rv  = 1;
        end else if (m_rv) begin
            exp_q.push_back({m_row, w[8:1], w[0]});
            m_ev++;
        end else begin
            m_drop++;
        end
    endtask

    task automatic wait_nack(input logic lvl, output int n);
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.AER_nack === lvl) return;
        end
        n = -1;
        checks++;
        errors++;
        $display("FAIL nack_timeout: got %0b expected %0b", bus.AER_nack, lvl);
    endtask

    task automatic hs(input logic [9:0] w, input bit lat, input int hold);
        int n;
        bit bad;
        @(posedge clk);
        #2;
        model(w);
        bus.AER_data = w;
        bus.AER_nreq = 1'b0;
        wait_nack(1'b0, n);
        if (lat) chk("req_latency", n, 4);
        bus.AER_data = 10'($urandom);
        if (hold > 0) begin
            bad = 0;
            repeat (hold) begin
                @(posedge clk);
                #1;
                if (bus.AER_nack !== 1'b0) bad = 1;
            end
            chk("nack_hold", 32'(bad), 0);
        end
        @(posedge clk);
        #2;
        bus.AER_nreq = 1'b1;
        wait_nack(1'b1, n);
        if (lat) chk("rel_latency", n, 3);
        chk("ev_cnt", 32'(ev_cnt), m_ev);
        chk("drop_cnt", 32'(drop_cnt), m_drop);
    endtask

    task automatic drain();
        int n = 0;
        while (fifo_count != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_count", 32'(fifo_count), 0);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        bus.ev_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.ev_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.ev_valid && bus.ev_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL event_unexpected: got %0h expected none",
                         {bus.ev_y, bus.ev_x, bus.ev_pol});
            end else begin
                chk("event", 32'({bus.ev_y, bus.ev_x, bus.ev_pol}),
                    32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [9:0] w;
        int n;
        bus.AER_nreq = 1'b1;
        bus.AER_data = '0;
        model_reset();
        rst = 1'b1;
        #1;
        chk("rst_nack", 32'(bus.AER_nack), 1);
        chk("rst_valid", 32'(bus.ev_valid), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_evcnt", 32'(ev_cnt), 0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        // column with no row: dropped, handshake still completes
        hs(10'h203, 1, 0);
        chk("drop_no_event", 32'(bus.ev_valid), 0);

        rdy_val = 1'b1;
        repeat (2) @(posedge clk);
        hs(10'h0A4, 1, 0);
        hs(10'h3A5, 1, 0);
        drain();

        hs(10'h105, 1, 0);
        for (int k = 0; k < 4; k++) hs({1'b1, 8'(k), 1'(k)}, 1, 0);
        hs(10'h006, 1, 0);
        for (int k = 0; k < 2; k++) hs({1'b1, 8'(k), 1'(k + 1)}, 1, 0);
        drain();

        hs({1'b1, 8'h33, 1'b0}, 1, 50);
        drain();

        // fill the FIFO, then stall the 17th column on backpressure
        rdy_val = 1'b0;
        repeat (3) @(posedge clk);
        hs(10'h011, 1, 0);
        for (int k = 0; k < 16; k++) hs({1'b1, 8'(k), 1'(k)}, 1, 0);
        chk("full_count", 32'(fifo_count), 16);
        @(posedge clk);
        #2;
        w = {1'b1, 8'd16, 1'b0};
        model(w);
        bus.AER_data = w;
        bus.AER_nreq = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        bus.AER_data = 10'($urandom);
        chk("stall_nack", 32'(bus.AER_nack), 1);
        chk("stall_count", 32'(fifo_count), 16);
        @(posedge clk);
        rdy_val = 1'b1;
        @(posedge clk);
        rdy_val = 1'b0;
        #2;
        chk("pop_nack", 32'(bus.AER_nack), 1);
        chk("pop_count", 32'(fifo_count), 15);
        @(posedge clk);
        #1;
        chk("late_push_nack", 32'(bus.AER_nack), 0);
        chk("late_push_count", 32'(fifo_count), 16);
        @(posedge clk);
        #2;
        bus.AER_nreq = 1'b1;
        wait_nack(1'b1, n);
        chk("stall_evcnt", 32'(ev_cnt), m_ev);
        rdy_val = 1'b1;
        drain();

        // reset in the middle of ACK
        @(posedge clk);
        #2;
        bus.AER_data = 10'h02A;
        bus.AER_nreq = 1'b0;
        wait_nack(1'b0, n);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("ack_rst_nack", 32'(bus.AER_nack), 1);
        chk("ack_rst_evcnt", 32'(ev_cnt), 0);
        chk("ack_rst_drop", 32'(drop_cnt), 0);
        chk("ack_rst_count", 32'(fifo_count), 0);
        model_reset();
        bus.AER_nreq = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        hs(10'h02B, 1, 0);
        hs({1'b1, 8'h7F, 1'b1}, 1, 0);
        drain();

        rdy_rand = 1'b1;
        repeat (40) begin
            w = 10'($urandom);
            w[9] = ($urandom_range(0, 2) != 0);
            hs(w, 0, 0);
        end
        rdy_rand = 1'b0;
        rdy_val  = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
